chad_coproc: RTL
================

Name: chad_coproc

Overview:
Sequential multiply/divide coprocessor that sits directly downstream of the chad core's coprocessor port.
- Consumes the core's start strobe, the 11-bit select field and the three operand buses (T, N, W).
- Produces the result word the core reads back with its COP ALU operation.
- Lets the core start a long multiply or divide and poll, or stall, until it completes.

Parameters:
WIDTH, 18, cell size in bits (16..32); must match the core's WIDTH.

Ports:
clk  input  1  system clock, rising edge.
resetq  input  1  asynchronous active-low reset.
hold  input  1  core hold; when high, no start is accepted and sequencing freezes.
copgo  input  1  start strobe from the core (insn[15:11]==5'b11101).
sel  input  11  operation select (the core's insn[10:0]).
copa  input  WIDTH  operand A (core T).
copb  input  WIDTH  operand B (core N).
copc  input  WIDTH  operand C (core W).
cop  output  WIDTH  result word returned to the core.
busy  output  1  an operation is in progress; may be ORed into the core's hold.

Behaviour:
- go = copgo & ~hold. Only sel[4:0] is decoded; sel[10:5] is reserved and ignored.
- op = sel[2:0]:
  - 0 = nop.
  - 1 = UMUL.
  - 2 = UDIV.
  - 3 = OSEL: outsel <= sel[4:3].
  - 4..7 = nop.
- Registers: hi, lo (WIDTH), ovf, outsel[1:0], cnt (ceil(log2(WIDTH+1)) bits), busy.
- Reset: hi=lo=0, ovf=0, outsel=0, cnt=0, busy=0. Therefore cop=0 and busy=0 out of reset.
- A reset asserted mid-operation aborts the operation immediately; reset values apply.
- cop mux (combinational from registers):
  - outsel 0 → lo.
  - outsel 1 → hi.
  - outsel 2 → {zero-extend, busy, ovf} with ovf at bit0 and busy at bit1.
  - outsel 3 → 0.
- UMUL start, when go and ~busy:
  - Capture multiplicand = copa, lo <= copb, hi <= 0, ovf <= 0, cnt <= WIDTH, busy <= 1.
  - Each non-hold cycle while busy: if lo[0], {c,hi} = hi + multiplicand, else c=0. Then {hi,lo} <= {c,hi,lo} >> 1 and cnt--.
  - busy clears in the cycle where cnt reaches 0.
  - Total: WIDTH busy cycles. The result {hi,lo} = copa*copb (unsigned, 2*WIDTH bits) is valid the cycle busy falls.
- UDIV start, when go and ~busy:
  - Dividend {copc,copb}, divisor copa.
  - If copc >= copa (includes copa==0): ovf <= 1, lo <= all ones, hi <= copc, busy stays 0. Done in 1 cycle.
  - Otherwise: ovf <= 0, hi <= copc, lo <= copb, capture divisor, cnt <= WIDTH, busy <= 1.
  - Restoring step per non-hold cycle: t = {hi,lo[WIDTH-1]} - divisor (WIDTH+1 bits). If t is non-negative, hi <= t[WIDTH-1:0] and quotient bit 1, else hi <= {hi,lo[MSB]} and quotient bit 0. lo <= {lo[WIDTH-2:0], qbit}.
  - Final result: lo = quotient, hi = remainder, after WIDTH busy cycles.
- Start while busy (op 1 or 2): ignored; the operation in progress is unaffected.
- OSEL is accepted while busy. Reading lo/hi while busy returns partial values (undefined use).
- hold high: cnt, hi, lo and busy all freeze; no start or OSEL is accepted.
- Same-cycle completion and go: the start is still ignored because busy is 1 in that cycle; software re-issues it.

Decomposition:
- Package chad_coproc_pkg:
  - op codes OP_NOP=0, OP_UMUL=1, OP_UDIV=2, OP_OSEL=3.
  - outsel codes OS_LO=0, OS_HI=1, OS_STAT=2, OS_ZERO=3.
  - status bit positions.
- One natural sub-module, chad_coproc_muldiv: the shared hi/lo/cnt datapath and step logic.
- The top level keeps the decode, outsel and cop mux.

Test Plan:
- All tests use WIDTH=18.
- Reset: assert resetq=0 mid-UMUL → busy=0 and cop=0 at once; after release, OSEL 2 reads 0.
- UMUL 1000×3000, then OSEL 0/1 → busy high exactly 18 cycles; lo=116416, hi=11.
- UMUL 0x3FFFF×0x3FFFF → hi=0x3FFFE, lo=0x00001, ovf=0.
- UDIV copc=0, copb=100, copa=7 → after 18 busy cycles lo=14, hi=2. Second UDIV issued at busy cycle 5 is ignored, so the result is unchanged.
- UDIV with copa=0, copc=5 → busy never rises; ovf=1, lo=0x3FFFF, hi=5; OSEL 2 → cop=1.
- UMUL 3×5 with hold high for 4 cycles mid-op → busy lasts 22 cycles; result lo=15, hi=0; copgo seen during hold is not accepted.

Source files
------------

// File: rtl/chad_coproc_pkg.sv
// Shared op codes, output-select codes and status bit positions for the chad multiply/divide coprocessor.
package chad_coproc_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_UMUL = 3'd1;
  localparam logic [2:0] OP_UDIV = 3'd2;
  localparam logic [2:0] OP_OSEL = 3'd3;

  typedef enum logic [1:0] {
    OS_LO   = 2'd0,
    OS_HI   = 2'd1,
    OS_STAT = 2'd2,
    OS_ZERO = 2'd3
  } outsel_e;

  localparam int unsigned ST_OVF_BIT  = 0;
  localparam int unsigned ST_BUSY_BIT = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/chad_coproc_muldiv.sv
// Shared hi/lo/cnt datapath: shift-add unsigned multiply and restoring unsigned divide, one bit per cycle.
module chad_coproc_muldiv
  import chad_coproc_pkg::*;
#(
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             hold,
  input  logic             i_start_mul,
  input  logic             i_start_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_ovf,
  output logic             o_busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  md_state_e        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic [WIDTH-1:0] r_opnd, w_opnd_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_busy, w_busy_nxt;

  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_dsub;

  // Multiply adds the multiplicand when lo[0] is set; divide trial-subtracts from the shifted remainder.
  assign w_msum = {1'b0, r_hi} + {1'b0, ({WIDTH{r_lo[0]}} & r_opnd)};
  assign w_dsub = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_opnd};

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opnd  <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_opnd  <= w_opnd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_opnd_nxt  = r_opnd;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    unique case (r_state)
      S_IDLE: begin
        if (i_start_mul) begin
          w_opnd_nxt  = i_a;
          w_lo_nxt    = i_b;
          w_hi_nxt    = '0;
          w_ovf_nxt   = 1'b0;
          w_cnt_nxt   = CW'(WIDTH);
          w_state_nxt = S_MUL;
        end else if (i_start_div) begin
          w_hi_nxt = i_c;
          // Quotient cannot fit (or divisor is zero): flag it and finish immediately.
          if (i_c >= i_a) begin
            w_ovf_nxt = 1'b1;
            w_lo_nxt  = '1;
          end else begin
            w_ovf_nxt   = 1'b0;
            w_lo_nxt    = i_b;
            w_opnd_nxt  = i_a;
            w_cnt_nxt   = CW'(WIDTH);
            w_state_nxt = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (!hold) begin
          w_hi_nxt  = w_msum[WIDTH:1];
          w_lo_nxt  = {w_msum[0], r_lo[WIDTH-1:1]};
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) w_state_nxt = S_IDLE;
        end
      end
      S_DIV: begin
        if (!hold) begin
          if (!w_dsub[WIDTH]) begin
            w_hi_nxt = w_dsub[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
          end else begin
            w_hi_nxt = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
          end
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_ovf  = r_ovf;
  assign o_busy = r_busy;

endmodule

// File: rtl/chad_coproc.sv
// chad multiply/divide coprocessor: decodes the core's COP strobe, holds the output select and muxes the result word.
module chad_coproc
  import chad_coproc_pkg::*;
#(
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             hold,
  input  logic             copgo,
  input  logic [10:0]      sel,
  input  logic [WIDTH-1:0] copa,
  input  logic [WIDTH-1:0] copb,
  input  logic [WIDTH-1:0] copc,
  output logic [WIDTH-1:0] cop,
  output logic             busy
);

  logic             w_go;
  logic [2:0]       w_op;
  logic             w_start_mul;
  logic             w_start_div;
  logic             w_osel;
  logic             w_unused_sel;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic             w_ovf;
  logic             w_busy;
  outsel_e          r_outsel;

  assign w_go         = copgo & ~hold;
  assign w_op         = sel[2:0];
  assign w_unused_sel = ^sel[10:5];

  // Long operations start only when idle; OSEL is honoured even mid-operation.
  always_comb begin
    w_start_mul = 1'b0;
    w_start_div = 1'b0;
    w_osel      = 1'b0;
    case (w_op)
      OP_NOP:  ;
      OP_UMUL: w_start_mul = w_go & ~w_busy;
      OP_UDIV: w_start_div = w_go & ~w_busy;
      OP_OSEL: w_osel      = w_go;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_outsel <= OS_LO;
    end else if (w_osel) begin
      r_outsel <= outsel_e'(sel[4:3]);
    end
  end

  chad_coproc_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk        (clk),
    .resetq     (resetq),
    .hold       (hold),
    .i_start_mul(w_start_mul),
    .i_start_div(w_start_div),
    .i_a        (copa),
    .i_b        (copb),
    .i_c        (copc),
    .o_hi       (w_hi),
    .o_lo       (w_lo),
    .o_ovf      (w_ovf),
    .o_busy     (w_busy)
  );

  always_comb begin
    cop = '0;
    unique case (r_outsel)
      OS_LO:   cop = w_lo;
      OS_HI:   cop = w_hi;
      OS_STAT: begin
        cop[ST_OVF_BIT]  = w_ovf;
        cop[ST_BUSY_BIT] = w_busy;
      end
      OS_ZERO: cop = '0;
      default: cop = '0;
    endcase
  end

  assign busy = w_busy;

endmodule
